// File: rtl/fruta_gen.sv
// fruta_gen: LFSR-driven search for an empty map cell to hold the next fruit position
module fruta_gen #(
   parameter int MAPA_WIDTH = 40,
   parameter int MAPA_HEIGHT = 30,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fruta_enable,
   output logic       fruta_wenable,
   output logic [9:0] fruta_wx,
   output logic [9:0] fruta_wy,
   output logic       fruta_ready,
   output logic       gen_renable,
   output logic [9:0] gen_rx,
   output logic [9:0] gen_ry,
   input  logic [1:0] gen_rdata
);
   typedef enum logic [2:0] {SEARCH, WAIT, CHECK, READY, RECHECK} state_t;
   state_t state, state_n;
   logic [15:0] lfsr;
   logic [9:0] cx, cy, cand_x, cand_y, rd_x, rd_y;
   logic [1:0] hold;
   logic waited, waited_n, rd, take, load, drop, occupied, same;
   assign cx = {4'd0, lfsr[5:0]};
   assign cy = {5'd0, lfsr[12:8]};
   assign occupied = gen_rdata != 2'b00;
   assign same = cand_x == fruta_wx && cand_y == fruta_wy;
   // rd requests a read strobe in the next cycle; its data is examined the cycle after that
   always_comb begin
      state_n = state;
      waited_n = 1'b0;
      rd = 1'b0;
      rd_x = cand_x;
      rd_y = cand_y;
      take = 1'b0;
      load = 1'b0;
      drop = 1'b0;
      case (state)
         SEARCH: begin
            if (cx < 10'(MAPA_WIDTH) && cy < 10'(MAPA_HEIGHT)) begin
               take = 1'b1;
               rd = 1'b1;
               rd_x = cx;
               rd_y = cy;
               state_n = WAIT;
            end
         end
         WAIT: state_n = CHECK;
         CHECK: begin
            if (waited) begin
               waited_n = hold != 2'd0;
               rd = hold == 2'd0;
               state_n = hold == 2'd0 ? WAIT : CHECK;
            end else if (occupied || same) begin
               state_n = SEARCH;
            end else if (hold != 2'd0) begin
               waited_n = 1'b1;
            end else begin
               load = 1'b1;
               rd = 1'b1;
               state_n = READY;
            end
         end
         READY: state_n = RECHECK;
         RECHECK: begin
            if (occupied) begin
               drop = 1'b1;
               state_n = SEARCH;
            end else begin
               rd = 1'b1;
               rd_x = fruta_wx;
               rd_y = fruta_wy;
               state_n = READY;
            end
         end
         default: state_n = SEARCH;
      endcase
      if (fruta_enable) begin
         state_n = SEARCH;
         waited_n = 1'b0;
         rd = 1'b0;
         take = 1'b0;
         load = 1'b0;
         drop = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEARCH;
         lfsr <= SEED;
         hold <= 2'd0;
         waited <= 1'b0;
         cand_x <= 10'd0;
         cand_y <= 10'd0;
         fruta_wenable <= 1'b0;
         fruta_wx <= 10'd13;
         fruta_wy <= 10'd13;
         fruta_ready <= 1'b0;
         gen_renable <= 1'b0;
         gen_rx <= 10'd0;
         gen_ry <= 10'd0;
      end else begin
         state <= state_n;
         waited <= waited_n;
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         hold <= fruta_enable ? 2'd2 : (hold != 2'd0 ? hold - 2'd1 : 2'd0);
         fruta_wenable <= fruta_enable;
         gen_renable <= rd;
         if (rd) begin
            gen_rx <= rd_x;
            gen_ry <= rd_y;
         end
         if (take) begin
            cand_x <= cx;
            cand_y <= cy;
         end
         if (load) begin
            fruta_wx <= cand_x;
            fruta_wy <= cand_y;
         end
         fruta_ready <= load | (fruta_ready & ~drop);
      end
   end
endmodule

// File: tb/tb_fruta_gen.sv
// tb_fruta_gen: randomized checks of fruta_gen against a search model driven by the LFSR sequence
module tb_fruta_gen;
   logic clk = 1'b0, reset = 1'b1, fruta_enable = 1'b0;
   logic fruta_wenable, fruta_ready, gen_renable;
   logic [9:0] fruta_wx, fruta_wy, gen_rx, gen_ry;
   logic [1:0] gen_rdata = 2'b00;
   logic [1:0] map [64][32];
   logic [15:0] m_lfsr = 16'hACE1;
   int n_cmp = 0, n_err = 0, n_bad = 0;

   fruta_gen dut (
      .clk(clk), .reset(reset), .fruta_enable(fruta_enable), .fruta_wenable(fruta_wenable),
      .fruta_wx(fruta_wx), .fruta_wy(fruta_wy), .fruta_ready(fruta_ready),
      .gen_renable(gen_renable), .gen_rx(gen_rx), .gen_ry(gen_ry), .gen_rdata(gen_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // map memory with one-cycle read latency, plus the spec LFSR sequence
   always @(posedge clk) begin
      m_lfsr <= reset ? 16'hACE1 : step(m_lfsr);
      if (gen_renable)
         gen_rdata <= (gen_rx < 10'd64 && gen_ry < 10'd32) ? map[gen_rx[5:0]][gen_ry[4:0]] : 2'b11;
   end

   always @(negedge clk)
      if (gen_renable && (gen_rx >= 10'd40 || gen_ry >= 10'd30)) n_bad++;

   // Each candidate costs 1 cycle if out of range, 3 cycles if read and rejected.
   function automatic void predict(input logic [15:0] l0, input int ox, input int oy,
                                   output int px, output int py, output int n);
      logic [15:0] l;
      int x, y;
      l = l0;
      px = -1;
      py = -1;
      n = 0;
      while (n < 200000) begin
         x = int'(l[5:0]);
         y = int'(l[12:8]);
         if (x < 40 && y < 30) begin
            if (map[x][y] == 2'b00 && !(x == ox && y == oy)) begin
               px = x;
               py = y;
               return;
            end
            for (int i = 0; i < 3; i++) l = step(l);
            n += 3;
         end else begin
            l = step(l);
            n++;
         end
      end
   endfunction

   task automatic map_fill(input logic [1:0] v);
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 32; y++) map[x][y] = v;
   endtask

   task automatic wait_ready(input int limit, output int cnt);
      cnt = 0;
      while (fruta_ready !== 1'b1 && cnt < limit) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic test_reset;
      int px, py, k, cnt;
      reset = 1'b1;
      fruta_enable = 1'b0;
      map_fill(2'b00);
      map[13][13] = 2'b10;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (fruta_wx !== 10'd13 || fruta_wy !== 10'd13) begin
         n_err++;
         $display("FAIL reset_pos: got %0d/%0d expected 13/13", fruta_wx, fruta_wy);
      end
      n_cmp++;
      if ({fruta_ready, fruta_wenable, gen_renable} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 000", {fruta_ready, fruta_wenable, gen_renable});
      end
      n_cmp++;
      if (gen_rx !== 10'd0 || gen_ry !== 10'd0) begin
         n_err++;
         $display("FAIL reset_raddr: got %0d/%0d expected 0/0", gen_rx, gen_ry);
      end
      reset = 1'b0;
      predict(m_lfsr, 13, 13, px, py, k);
      wait_ready(k + 10, cnt);
      n_cmp++;
      if (cnt != k + 3) begin
         n_err++;
         $display("FAIL reset_latency: got %0d cycles expected %0d", cnt, k + 3);
      end
      n_cmp++;
      if (fruta_ready !== 1'b1 || fruta_wx !== 10'(px) || fruta_wy !== 10'(py)) begin
         n_err++;
         $display("FAIL reset_first: got %0d/%0d rdy %b expected %0d/%0d rdy 1", fruta_wx, fruta_wy, fruta_ready, px, py);
      end
      n_cmp++;
      if (fruta_wx >= 10'd40 || fruta_wy >= 10'd30 || (fruta_wx == 10'd13 && fruta_wy == 10'd13)) begin
         n_err++;
         $display("FAIL reset_range: got %0d/%0d expected in map and not 13/13", fruta_wx, fruta_wy);
      end
   endtask

   task automatic test_request;
      int px, py, k, cnt;
      logic [9:0] p_x, p_y;
      p_x = fruta_wx;
      p_y = fruta_wy;
      fruta_enable = 1'b1;
      @(negedge clk);
      fruta_enable = 1'b0;
      n_cmp++;
      if (fruta_wenable !== 1'b1 || fruta_ready !== 1'b0 || fruta_wx !== p_x || fruta_wy !== p_y) begin
         n_err++;
         $display("FAIL req_ack: got we %b rdy %b %0d/%0d expected we 1 rdy 0 %0d/%0d", fruta_wenable, fruta_ready, fruta_wx, fruta_wy, p_x, p_y);
      end
      predict(m_lfsr, int'(p_x), int'(p_y), px, py, k);
      @(negedge clk);
      n_cmp++;
      if (fruta_wenable !== 1'b0 || fruta_wx !== p_x || fruta_wy !== p_y) begin
         n_err++;
         $display("FAIL req_pulse: got we %b %0d/%0d expected we 0 %0d/%0d", fruta_wenable, fruta_wx, fruta_wy, p_x, p_y);
      end
      @(negedge clk);
      n_cmp++;
      if (fruta_wx !== p_x || fruta_wy !== p_y) begin
         n_err++;
         $display("FAIL req_hold: got %0d/%0d expected %0d/%0d", fruta_wx, fruta_wy, p_x, p_y);
      end
      wait_ready(k + 10, cnt);
      n_cmp++;
      if (cnt != k + 1) begin
         n_err++;
         $display("FAIL req_latency: got %0d cycles expected %0d", cnt, k + 1);
      end
      n_cmp++;
      if (fruta_ready !== 1'b1 || fruta_wx !== 10'(px) || fruta_wy !== 10'(py) || (fruta_wx == p_x && fruta_wy == p_y)) begin
         n_err++;
         $display("FAIL req_new: got %0d/%0d rdy %b expected %0d/%0d rdy 1", fruta_wx, fruta_wy, fruta_ready, px, py);
      end
   endtask

   task automatic test_single_cell;
      int px, py, k, cnt, bad0, tx;
      bad0 = n_bad;
      tx = (fruta_wx == 10'd7 && fruta_wy == 10'd21) ? 8 : 7;
      map_fill(2'b01);
      map[tx][21] = 2'b00;
      fruta_enable = 1'b1;
      @(negedge clk);
      fruta_enable = 1'b0;
      predict(m_lfsr, int'(fruta_wx), int'(fruta_wy), px, py, k);
      wait_ready(40000, cnt);
      n_cmp++;
      if (cnt != k + 3) begin
         n_err++;
         $display("FAIL single_latency: got %0d cycles expected %0d", cnt, k + 3);
      end
      n_cmp++;
      if (fruta_ready !== 1'b1 || fruta_wx !== 10'(tx) || fruta_wy !== 10'd21) begin
         n_err++;
         $display("FAIL single_pos: got %0d/%0d rdy %b expected %0d/21 rdy 1", fruta_wx, fruta_wy, fruta_ready, tx);
      end
      n_cmp++;
      if (n_bad != bad0) begin
         n_err++;
         $display("FAIL read_range: got %0d out-of-map reads expected 0", n_bad - bad0);
      end
   endtask

   task automatic test_flip;
      int px, py, k, cnt;
      logic [9:0] p_x, p_y;
      map_fill(2'b00);
      repeat (3 + $urandom_range(0, 1)) @(negedge clk);
      p_x = fruta_wx;
      p_y = fruta_wy;
      map[p_x[5:0]][p_y[4:0]] = 2'b01;
      cnt = 0;
      while (fruta_ready !== 1'b0 && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      n_cmp++;
      if (fruta_ready !== 1'b0 || cnt > 3) begin
         n_err++;
         $display("FAIL flip_drop: got rdy %b after %0d cycles expected 0 within 3", fruta_ready, cnt);
      end
      predict(m_lfsr, int'(p_x), int'(p_y), px, py, k);
      wait_ready(k + 10, cnt);
      n_cmp++;
      if (cnt != k + 3 || fruta_wx !== 10'(px) || fruta_wy !== 10'(py) || (fruta_wx == p_x && fruta_wy == p_y)) begin
         n_err++;
         $display("FAIL flip_resettle: got %0d/%0d in %0d cycles expected %0d/%0d in %0d", fruta_wx, fruta_wy, cnt, px, py, k + 3);
      end
   endtask

   task automatic test_back_to_back;
      int px, py, k, cnt, n;
      logic [9:0] p_x, p_y;
      n = $urandom_range(2, 4);
      p_x = fruta_wx;
      p_y = fruta_wy;
      fruta_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == n - 1) fruta_enable = 1'b0;
         n_cmp++;
         if (fruta_wenable !== 1'b1 || fruta_ready !== 1'b0 || fruta_wx !== p_x || fruta_wy !== p_y) begin
            n_err++;
            $display("FAIL b2b_ack%0d: got we %b rdy %b %0d/%0d expected we 1 rdy 0 %0d/%0d", i, fruta_wenable, fruta_ready, fruta_wx, fruta_wy, p_x, p_y);
         end
      end
      predict(m_lfsr, int'(p_x), int'(p_y), px, py, k);
      @(negedge clk);
      n_cmp++;
      if (fruta_wenable !== 1'b0 || fruta_wx !== p_x || fruta_wy !== p_y) begin
         n_err++;
         $display("FAIL b2b_end: got we %b %0d/%0d expected we 0 %0d/%0d", fruta_wenable, fruta_wx, fruta_wy, p_x, p_y);
      end
      @(negedge clk);
      wait_ready(k + 10, cnt);
      n_cmp++;
      if (cnt != k + 1 || fruta_wx !== 10'(px) || fruta_wy !== 10'(py)) begin
         n_err++;
         $display("FAIL b2b_new: got %0d/%0d in %0d cycles expected %0d/%0d in %0d", fruta_wx, fruta_wy, cnt, px, py, k + 1);
      end
   endtask

   task automatic test_full_map;
      logic [9:0] p_x, p_y;
      logic seen;
      map_fill(2'b11);
      p_x = fruta_wx;
      p_y = fruta_wy;
      fruta_enable = 1'b1;
      @(negedge clk);
      fruta_enable = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= fruta_ready;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL full_no_ready: got rdy seen %b expected 0", seen);
      end
      fruta_enable = 1'b1;
      @(negedge clk);
      fruta_enable = 1'b0;
      n_cmp++;
      if (fruta_wenable !== 1'b1 || fruta_wx !== p_x || fruta_wy !== p_y) begin
         n_err++;
         $display("FAIL full_ack: got we %b %0d/%0d expected we 1 %0d/%0d", fruta_wenable, fruta_wx, fruta_wy, p_x, p_y);
      end
   endtask

   task automatic test_reset_mid_search;
      int px, py, k, cnt;
      map_fill(2'b00);
      map[13][13] = 2'b10;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (fruta_wx !== 10'd13 || fruta_wy !== 10'd13 || {fruta_ready, gen_renable, fruta_wenable} !== 3'b000) begin
         n_err++;
         $display("FAIL midreset: got %0d/%0d flags %b expected 13/13 flags 000", fruta_wx, fruta_wy, {fruta_ready, gen_renable, fruta_wenable});
      end
      reset = 1'b0;
      predict(m_lfsr, 13, 13, px, py, k);
      wait_ready(k + 10, cnt);
      n_cmp++;
      if (cnt != k + 3 || fruta_wx !== 10'(px) || fruta_wy !== 10'(py)) begin
         n_err++;
         $display("FAIL midreset_resettle: got %0d/%0d in %0d cycles expected %0d/%0d in %0d", fruta_wx, fruta_wy, cnt, px, py, k + 3);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 8; it++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
               map[x][y] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         test_request();
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_request();
      test_single_cell();
      test_flip();
      test_back_to_back();
      test_full_map();
      test_reset_mid_search();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
